// File: rtl/access_pkg.sv
// access_pkg: shared types and constants for the access_check credential checker.
//   state_t          - controller state encoding
//   TABLE_SIZE       - number of entries in the built-in credential table
//   USER_ID/USER_PW  - credential table, entry i is the pair (USER_ID[i], USER_PW[i])
//   STATUS_*         - codes presented on the status output to the LCD/LED selection logic
package access_pkg;

  typedef enum logic [2:0] {
    IDLE_ID,
    IDLE_PW,
    SEARCH,
    GRANT,
    DENY,
    LOCK
  } state_t;

  localparam int TABLE_SIZE = 4;

  localparam logic [15:0] USER_ID [TABLE_SIZE] = '{16'h1234, 16'h0042, 16'h1111, 16'hBEEF};
  localparam logic [15:0] USER_PW [TABLE_SIZE] = '{16'hABCD, 16'h0007, 16'h2222, 16'hCAFE};

  localparam logic [1:0] STATUS_ID     = 2'd0;
  localparam logic [1:0] STATUS_PW     = 2'd1;
  localparam logic [1:0] STATUS_DENIED = 2'd2;
  localparam logic [1:0] STATUS_LOCKED = 2'd3;

endpackage

// File: rtl/access_check_if.sv
// access_check_if: handshake between the process-control FSM (master) and the
// credential checker (slave).
//   userinput         - ID or password value from the switches (master -> slave)
//   load              - level strobe, each rising edge is one entry (master -> slave)
//   access_control_fb - one-cycle grant pulse (slave -> master)
//   deny              - one-cycle deny pulse (slave -> master)
//   locked            - high for the whole lockout (slave -> master)
//   user_index        - matched table entry, held after a grant (slave -> master)
//   status            - 0 ID, 1 password, 2 denied, 3 locked (slave -> master)
interface access_check_if #(
  parameter int NUM_USERS = 4
) ();

  localparam int IDX_W = $clog2(NUM_USERS);

  logic [15:0]      userinput;
  logic             load;
  logic             access_control_fb;
  logic             deny;
  logic             locked;
  logic [IDX_W-1:0] user_index;
  logic [1:0]       status;

  modport master (
    output userinput, load,
    input  access_control_fb, deny, locked, user_index, status
  );

  modport slave (
    input  userinput, load,
    output access_control_fb, deny, locked, user_index, status
  );

endinterface

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter used to time the lockout period.
//   clk, rst   - clock and asynchronous active-low reset
//   load       - loads load_value (takes priority over dec)
//   load_value - start value, the counter reaches zero load_value cycles later
//   dec        - decrement enable, the counter holds at zero
//   done       - high while the count is zero
module lock_timer #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/access_check.sv
// access_check: credential checker on the responder side of the access-control
// handshake. Captures an ID then a password on rising edges of load, scans the
// credential table one entry per cycle, and answers with a one-cycle grant or
// deny pulse. MAX_FAILS consecutive denials lock the block out for LOCK_CYCLES.
//   clk, rst - clock and asynchronous active-low reset
//   bus      - access_check_if slave modport (userinput/load in, results out)
// NUM_USERS must not exceed the package credential table size.
module access_check
  import access_pkg::*;
#(
  parameter int NUM_USERS   = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  access_check_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_USERS);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_USERS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

  state_t            state;
  logic              load_q;
  logic [15:0]       id_r;
  logic [15:0]       pw_r;
  logic [IDX_W-1:0]  idx;
  logic [FAIL_W-1:0] fail_cnt;
  logic [FAIL_W-1:0] fail_next;

  logic              grant_q;
  logic              deny_q;
  logic              locked_q;
  logic [IDX_W-1:0]  user_index_q;
  logic [1:0]        status_q;

  logic              load_edge;
  logic              entry_match;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_done;

  // load is already synchronous to clk, so a single delay stage suffices.
  assign load_edge   = bus.load & ~load_q;
  assign entry_match = (id_r == USER_ID[idx]) && (pw_r == USER_PW[idx]);

  // Saturating so a stuck count can never wrap back below the lockout threshold.
  assign fail_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FAIL_W'(1);

  // Timer is loaded on the denial that reaches the threshold, then counts down
  // through the LOCK state; LOCK ends in the cycle it reads zero.
  assign timer_load = (state == DENY) && (fail_next == FAIL_MAX);
  assign timer_dec  = (state == LOCK);

  lock_timer #(.WIDTH(LOCK_W)) u_lock_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (LOCK_LOAD),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  // Controller. All outputs are registered and set on the transition into the
  // state they describe, so they line up with that state. load_q always tracks
  // load, which makes edges arriving outside the IDLE states vanish for good.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE_ID;
      load_q       <= 1'b0;
      id_r         <= '0;
      pw_r         <= '0;
      idx          <= '0;
      fail_cnt     <= '0;
      grant_q      <= 1'b0;
      deny_q       <= 1'b0;
      locked_q     <= 1'b0;
      user_index_q <= '0;
      status_q     <= STATUS_ID;
    end else begin
      load_q  <= bus.load;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      case (state)
        IDLE_ID: begin
          if (load_edge) begin
            id_r     <= bus.userinput;
            status_q <= STATUS_PW;
            state    <= IDLE_PW;
          end
        end
        IDLE_PW: begin
          if (load_edge) begin
            pw_r  <= bus.userinput;
            idx   <= '0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (entry_match) begin
            user_index_q <= idx;
            fail_cnt     <= '0;
            grant_q      <= 1'b1;
            status_q     <= STATUS_ID;
            state        <= GRANT;
          end else if (idx == LAST_IDX) begin
            deny_q   <= 1'b1;
            status_q <= STATUS_DENIED;
            state    <= DENY;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        GRANT: begin
          state <= IDLE_ID;
        end
        DENY: begin
          fail_cnt <= fail_next;
          if (fail_next == FAIL_MAX) begin
            locked_q <= 1'b1;
            status_q <= STATUS_LOCKED;
            state    <= LOCK;
          end else begin
            state <= IDLE_ID;
          end
        end
        LOCK: begin
          if (timer_done) begin
            locked_q <= 1'b0;
            fail_cnt <= '0;
            status_q <= STATUS_ID;
            state    <= IDLE_ID;
          end
        end
        default: begin
          state <= IDLE_ID;
        end
      endcase
    end
  end

  assign bus.access_control_fb = grant_q;
  assign bus.deny              = deny_q;
  assign bus.locked            = locked_q;
  assign bus.user_index        = user_index_q;
  assign bus.status            = status_q;

endmodule

// File: tb/tb_access_check.sv
// tb_access_check: scoreboard bench for access_check with a short lockout.
// Stimulus pushes predicted pulses into a queue; a monitor on the falling edge
// pops and compares them and tracks the predicted lockout window every cycle.
module tb_access_check;

  localparam int NUM_USERS   = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 8;

  localparam logic [15:0] REF_ID [NUM_USERS] = '{16'h1234, 16'h0042, 16'h1111, 16'hBEEF};
  localparam logic [15:0] REF_PW [NUM_USERS] = '{16'hABCD, 16'h0007, 16'h2222, 16'hCAFE};

  typedef struct {
    bit is_grant;
    int at;
    int idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   model_fails = 0;
  int   lock_lo = -10;
  int   lock_hi = -10;
  exp_t sb[$];

  access_check_if #(.NUM_USERS(NUM_USERS)) bus ();

  access_check #(
    .NUM_USERS   (NUM_USERS),
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Index of the first table entry holding exactly this pair, -1 if none.
  function automatic int refLookup(input logic [15:0] id, input logic [15:0] pw);
    for (int i = 0; i < NUM_USERS; i++) begin
      if (REF_ID[i] == id && REF_PW[i] == pw) return i;
    end
    return -1;
  endfunction

  // Monitor: pulses are matched against the scoreboard, locked against the window.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   exp_locked;
    if (rst) begin
      if (bus.access_control_fb || bus.deny) begin
        checkOutput("pulse expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("grant pulse", int'(bus.access_control_fb), int'(e.is_grant));
          checkOutput("deny pulse", int'(bus.deny), int'(!e.is_grant));
          checkOutput("pulse cycle", cyc, e.at);
          if (e.is_grant) checkOutput("user_index", int'(bus.user_index), e.idx);
          else            checkOutput("deny status", int'(bus.status), 2);
        end
      end
      exp_locked = (cyc >= lock_lo) && (cyc <= lock_hi);
      checkOutput("locked", int'(bus.locked), int'(exp_locked));
      if (exp_locked) checkOutput("lock status", int'(bus.status), 3);
    end
  end

  // Waits for all predicted pulses and any predicted lockout to pass; optionally
  // toggles load during the lockout, which the DUT must ignore.
  task automatic waitDrained(input bit poke);
    int budget = 60;
    while ((sb.size() != 0 || cyc <= lock_hi) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (poke && cyc >= lock_lo && cyc < lock_hi - 1) begin
        bus.userinput = 16'($urandom);
        bus.load      = ~bus.load;
      end else if (poke && cyc >= lock_lo) begin
        bus.load = 1'b0;
      end
    end
    checkOutput("pending responses", int'(sb.size()), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  // One login attempt: ID edge, password edge, prediction pushed at the password edge.
  task automatic applyStimulus(input logic [15:0] id, input logic [15:0] pw,
                               input bit hold, input bit poke);
    exp_t item;
    int   e;
    int   k;
    bit   locks;
    @(negedge clk);
    bus.userinput = id;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    bus.userinput = pw;
    bus.load      = 1'b1;
    e     = cyc;
    k     = refLookup(id, pw);
    locks = 1'b0;
    if (k >= 0) begin
      item.is_grant = 1'b1;
      item.at       = e + 2 + k;
      item.idx      = k;
      model_fails   = 0;
    end else begin
      item.is_grant = 1'b0;
      item.at       = e + 1 + NUM_USERS;
      item.idx      = 0;
      model_fails++;
      if (model_fails == MAX_FAILS) begin
        lock_lo     = item.at + 1;
        lock_hi     = item.at + LOCK_CYCLES;
        model_fails = 0;
        locks       = 1'b1;
      end
    end
    sb.push_back(item);
    if (!hold) begin
      @(negedge clk);
      bus.load = 1'b0;
    end
    waitDrained(poke);
    checkOutput("status after attempt", int'(bus.status), (k >= 0 || locks) ? 0 : 2);
  endtask

  initial begin : watchdog
    #2_000_000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r;
    int i;
    int j;
    bus.userinput = '0;
    bus.load      = 1'b0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset grant", int'(bus.access_control_fb), 0);
    checkOutput("reset deny", int'(bus.deny), 0);
    checkOutput("reset locked", int'(bus.locked), 0);
    checkOutput("reset user_index", int'(bus.user_index), 0);
    checkOutput("reset status", int'(bus.status), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] grant on last and first entries");
    applyStimulus(16'hBEEF, 16'hCAFE, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'hABCD, 1'b0, 1'b0);
    applyStimulus(16'hBEEF, 16'hCAFE, 1'b0, 1'b0);

    $display("[TB] reset during search");
    @(negedge clk);
    bus.userinput = 16'h1111;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    bus.userinput = 16'h1111;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_fails = 0;
    #1;
    checkOutput("mid-search reset user_index", int'(bus.user_index), 0);
    checkOutput("mid-search reset status", int'(bus.status), 0);
    checkOutput("mid-search reset pulses", int'(bus.access_control_fb | bus.deny | bus.locked), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(16'h0042, 16'h0007, 1'b0, 1'b0);

    $display("[TB] mismatched pair then recovery");
    applyStimulus(16'h1234, 16'hCAFE, 1'b0, 1'b0);
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);

    $display("[TB] lockout with ignored edges");
    applyStimulus(16'h1234, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0042, 16'hCAFE, 1'b0, 1'b0);
    applyStimulus(16'hDEAD, 16'hBEEF, 1'b0, 1'b1);

    $display("[TB] load held across grant");
    applyStimulus(16'h0042, 16'h0007, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("held load status", int'(bus.status), 0);
    bus.load = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);

    $display("[TB] randomized attempts");
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 3);
      i = $urandom_range(0, NUM_USERS - 1);
      j = (i + $urandom_range(1, NUM_USERS - 1)) % NUM_USERS;
      case (r)
        0, 1:    applyStimulus(REF_ID[i], REF_PW[i], 1'b0, 1'($urandom_range(0, 1)));
        2:       applyStimulus(REF_ID[i], REF_PW[j], 1'b0, 1'($urandom_range(0, 1)));
        default: applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      endcase
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
